// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM (fetch/decode/exec/mem/wb) with retire counter and sticky illegal-opcode trap.
// Memory waits stall in FETCH/MEM_RD/MEM_WR on mem_ready; define RV_CTRL_ADDI_EN to add the EXEC_I (ADDI) path.
module rv_multicycle_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alusrc_a,
  output logic [1:0]          alusrc_b,
  output logic [1:0]          aluop,
  output logic                reg_write,
  output logic                memtoreg,
  output logic                trap,
  output logic [3:0]          state_o,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WR   = 4'd4;
  localparam logic [3:0] S_WB_MEM   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_TRAP     = 4'd9;
`ifdef RV_CTRL_ADDI_EN
  localparam logic [3:0] S_EXEC_I   = 4'd10;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef RV_CTRL_ADDI_EN
  localparam logic [6:0] OP_IMM    = 7'b0010011;
`endif

  logic [3:0]          state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef RV_CTRL_ADDI_EN
          OP_IMM:            state_d = S_EXEC_I;
`endif
          default:           state_d = S_TRAP;
        endcase
      end
      // The IR still holds the load/store opcode here.
      S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_MEM: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC_R: state_d = S_WB_ALU;
`ifdef RV_CTRL_ADDI_EN
      S_EXEC_I: state_d = S_WB_ALU;
`endif
      S_WB_ALU: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alusrc_a  = 1'b0;
    alusrc_b  = 2'b00;
    aluop     = 2'b00;
    reg_write = 1'b0;
    memtoreg  = 1'b0;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        alusrc_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      // Branch target computed here and latched into ALUOut.
      S_DECODE: alusrc_b = 2'b10;
      S_MEM_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
      end
      S_MEM_RD: mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
      end
      S_EXEC_R: begin
        alusrc_a = 1'b1;
        aluop    = 2'b10;
      end
`ifdef RV_CTRL_ADDI_EN
      S_EXEC_I: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
      end
`endif
      S_WB_ALU: reg_write = 1'b1;
      S_BRANCH: begin
        alusrc_a = 1'b1;
        aluop    = 2'b01;
        pc_src   = 1'b1;
        pc_write = zero;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state_o = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed vector bench for rv_multicycle_ctrl (RETIRE_W=4 so the counter wrap is reachable).
module tb_rv_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] ILL = 7'b1111111;
  localparam logic [6:0] ADI = 7'b0010011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = RT;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write, pc_src, alusrc_a;
  logic [1:0] alusrc_b, aluop;
  logic       reg_write, memtoreg, trap;
  logic [3:0] state_o;
  logic [3:0] retired;

  rv_multicycle_ctrl #(.RETIRE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop),
    .reg_write(reg_write), .memtoreg(memtoreg), .trap(trap), .state_o(state_o),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, mwe, irw, pcw, pcsrc, asa;
    logic [1:0] asb, aop;
    logic       rw, m2r, trp;
    logic [3:0] ret;
  } out_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       z;
    logic       mr;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cycles;
  int   irw_cnt;

  function automatic out_t mk(input logic [3:0] st, input logic mreq, input logic mwe,
                              input logic irw, input logic pcw, input logic pcsrc,
                              input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                              input logic rw, input logic m2r, input logic trp,
                              input logic [3:0] ret);
    out_t o;
    o.st = st; o.mreq = mreq; o.mwe = mwe; o.irw = irw; o.pcw = pcw; o.pcsrc = pcsrc;
    o.asa = asa; o.asb = asb; o.aop = aop; o.rw = rw; o.m2r = m2r; o.trp = trp; o.ret = ret;
    return o;
  endfunction

  function automatic out_t act();
    out_t o;
    o.st = state_o; o.mreq = mem_req; o.mwe = mem_we; o.irw = ir_write; o.pcw = pc_write;
    o.pcsrc = pc_src; o.asa = alusrc_a; o.asb = alusrc_b; o.aop = aluop;
    o.rw = reg_write; o.m2r = memtoreg; o.trp = trap; o.ret = retired;
    return o;
  endfunction

  task automatic v(input logic r, input logic [6:0] op, input logic z, input logic mr, input out_t e);
    vec_t t;
    t.rst = r; t.op = op; t.z = z; t.mr = mr; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic drv(input logic r, input logic [6:0] op, input logic z, input logic mr);
    @(negedge clk);
    rst = r; opcode = op; zero = z; mem_ready = mr;
    #1;
  endtask

  task automatic chk(input string name, input out_t e);
    out_t a;
    a = act();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h", name, a.st, a, e.st, e);
    end
  endtask

  task automatic chk_int(input string name, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, a, e);
    end
  endtask

  task automatic step(input string name, input logic r, input logic [6:0] op, input logic z,
                      input logic mr, input out_t e);
    drv(r, op, z, mr);
    chk(name, e);
    cycles++;
    if (ir_write) irw_cnt++;
  endtask

  initial begin
    // R-type after a 2-cycle reset
    v(1, RT, 0, 1, mk(0, 0,0,0,0,0,0, 2'b01, 2'b00, 0,0,0, 0));
    v(1, RT, 0, 1, mk(0, 0,0,0,0,0,0, 2'b01, 2'b00, 0,0,0, 0));
    v(0, RT, 0, 1, mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 0));
    v(0, RT, 0, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 0));
    v(0, RT, 0, 1, mk(6, 0,0,0,0,0,1, 2'b00, 2'b10, 0,0,0, 0));
    v(0, RT, 0, 1, mk(7, 0,0,0,0,0,0, 2'b00, 2'b00, 1,0,0, 0));
    // SW
    v(0, SW, 0, 1, mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 1));
    v(0, SW, 0, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 1));
    v(0, SW, 0, 1, mk(2, 0,0,0,0,0,1, 2'b10, 2'b00, 0,0,0, 1));
    v(0, SW, 0, 1, mk(4, 1,1,0,0,0,0, 2'b00, 2'b00, 0,0,0, 1));
    // BEQ taken, then not taken
    v(0, BEQ, 1, 1, mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 2));
    v(0, BEQ, 1, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 2));
    v(0, BEQ, 1, 1, mk(8, 0,0,0,1,1,1, 2'b00, 2'b01, 0,0,0, 2));
    v(0, BEQ, 0, 1, mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 3));
    v(0, BEQ, 0, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 3));
    v(0, BEQ, 0, 1, mk(8, 0,0,0,0,1,1, 2'b00, 2'b01, 0,0,0, 3));
    // Illegal opcode: trap is sticky regardless of mem_ready/opcode
    v(0, ILL, 0, 1, mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 4));
    v(0, ILL, 0, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 4));
    for (int i = 0; i < 20; i++)
      v(0, (i % 2) ? RT : ILL, 0, i[0], mk(9, 0,0,0,0,0,0, 2'b00, 2'b00, 0,0,1, 4));
    v(1, RT, 0, 0, mk(9, 0,0,0,0,0,0, 2'b00, 2'b00, 0,0,1, 4));
    v(0, RT, 0, 0, mk(0, 1,0,0,0,0,0, 2'b01, 2'b00, 0,0,0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drv(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // LW with 3 FETCH wait cycles and 2 MEM_RD wait cycles
    drv(1, LW, 0, 0);
    cycles = 0; irw_cnt = 0;
    for (int i = 0; i < 3; i++)
      step("lw_fetch_wait", 0, LW, 0, 0, mk(0, 1,0,0,0,0,0, 2'b01, 2'b00, 0,0,0, 0));
    step("lw_fetch",   0, LW, 0, 1, mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 0));
    step("lw_decode",  0, LW, 0, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 0));
    step("lw_addr",    0, LW, 0, 1, mk(2, 0,0,0,0,0,1, 2'b10, 2'b00, 0,0,0, 0));
    for (int i = 0; i < 2; i++)
      step("lw_rd_wait", 0, LW, 0, 0, mk(3, 1,0,0,0,0,0, 2'b00, 2'b00, 0,0,0, 0));
    step("lw_rd",      0, LW, 0, 1, mk(3, 1,0,0,0,0,0, 2'b00, 2'b00, 0,0,0, 0));
    step("lw_wb",      0, LW, 0, 1, mk(5, 0,0,0,0,0,0, 2'b00, 2'b00, 1,1,0, 0));
    chk_int("lw_cycles", cycles, 10);
    chk_int("lw_ir_write_pulses", irw_cnt, 1);

    // ADDI opcode: EXEC_I path only when the option is built in
    step("addi_fetch",  0, ADI, 0, 1, mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 1));
    step("addi_decode", 0, ADI, 0, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 1));
`ifdef RV_CTRL_ADDI_EN
    step("addi_exec",   0, ADI, 0, 1, mk(10, 0,0,0,0,0,1, 2'b10, 2'b00, 0,0,0, 1));
    step("addi_wb",     0, ADI, 0, 1, mk(7, 0,0,0,0,0,0, 2'b00, 2'b00, 1,0,0, 1));
    step("addi_done",   0, ADI, 0, 0, mk(0, 1,0,0,0,0,0, 2'b01, 2'b00, 0,0,0, 2));
`else
    step("addi_trap",   0, ADI, 0, 1, mk(9, 0,0,0,0,0,0, 2'b00, 2'b00, 0,0,1, 1));
`endif

    // Counter wrap: 16 R-types on a 4-bit counter
    drv(1, RT, 0, 1);
    for (int i = 0; i <= 16; i++) begin
      step($sformatf("wrap_fetch%0d", i), 0, RT, 0, 1,
           mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 4'(i)));
      if (i < 16) begin
        drv(0, RT, 0, 1);
        drv(0, RT, 0, 1);
        drv(0, RT, 0, 1);
      end
    end

    // Reset in EXEC_R and in WB_ALU abandons the instruction
    step("rst_decode", 0, RT, 0, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 0));
    step("rst_in_exec", 1, RT, 0, 1, mk(6, 0,0,0,0,0,1, 2'b00, 2'b10, 0,0,0, 0));
    step("rst_after_exec", 0, RT, 0, 1, mk(0, 1,0,1,1,0,0, 2'b01, 2'b00, 0,0,0, 0));
    step("rst_decode2", 0, RT, 0, 1, mk(1, 0,0,0,0,0,0, 2'b10, 2'b00, 0,0,0, 0));
    step("rst_exec2", 0, RT, 0, 1, mk(6, 0,0,0,0,0,1, 2'b00, 2'b10, 0,0,0, 0));
    step("rst_in_wb", 1, RT, 0, 1, mk(7, 0,0,0,0,0,0, 2'b00, 2'b00, 0,0,0, 0));
    step("rst_after_wb", 0, RT, 0, 0, mk(0, 1,0,0,0,0,0, 2'b01, 2'b00, 0,0,0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
